// File: rtl/branch_pred_pkg.sv
// Shared types, counter-state names and the saturating step used by the
// branch history table.
package branch_pred_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Widest counter the shared step function handles.
  localparam int unsigned MAX_CNT_W = 8;

  // Named states of the classic 2-bit counter.
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // One training step: move toward the outcome, clamp at 0 and cnt_max.
  function automatic logic [MAX_CNT_W-1:0] sat_next(
    input logic [MAX_CNT_W-1:0] cnt,
    input logic                 taken,
    input logic [MAX_CNT_W-1:0] cnt_max
  );
    logic [MAX_CNT_W-1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != cnt_max) res = cnt + MAX_CNT_W'(1);
    end else begin
      if (cnt != '0) res = cnt - MAX_CNT_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_sat_upd.sv
// Next-value logic for one saturating counter on the table write path.
module bp_sat_upd
  import branch_pred_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_taken,
  output logic [CNT_W-1:0] o_cnt_c
);

  localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((1 << CNT_W) - 1);

  assign o_cnt_c = CNT_W'(sat_next(MAX_CNT_W'(i_cnt), i_taken, CNT_MAX));

endmodule

// File: rtl/branch_pred_sat.sv
// Branch history table of saturating counters: zero-latency lookup at decode,
// training at execute, post-reset init sweep and update/mispredict statistics.
module branch_pred_sat
  import branch_pred_pkg::*;
#(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INIT_VAL = 2**(CNT_W-1) - 1,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  addrD,
  output logic              predD,
  output logic [CNT_W-1:0]  ctrD,
  input  logic [IDX_W-1:0]  addrE,
  input  logic              updE,
  input  logic              takenE,
  input  logic              predE,
  output logic              busy,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] upd_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int unsigned      DEPTH    = 2**IDX_W;
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  bp_state_e         r_state;
  bp_state_e         w_state_nxt;
  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_mem [DEPTH];
  logic [STAT_W-1:0] r_upd_cnt;
  logic [STAT_W-1:0] r_miss_cnt;
  logic              w_busy;
  logic              w_upd_ok;
  logic [CNT_W-1:0]  w_ctr_rd;
  logic [CNT_W-1:0]  w_ctr_e;
  logic [CNT_W-1:0]  w_ctr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  // Sweep ends once the last entry has been written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_ptr == PTR_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == ST_INIT);
    w_upd_ok = (r_state == ST_RUN) && updE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      r_ptr <= '0;
    else if (w_busy) r_ptr <= r_ptr + IDX_W'(1);
  end

  // Table has no reset; the sweep owns initialisation.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_busy)        r_mem[r_ptr] <= CNT_W'(INIT_VAL);
      else if (w_upd_ok) r_mem[addrE] <= w_ctr_nxt;
    end
  end

  assign w_ctr_e = r_mem[addrE];

  bp_sat_upd #(
    .CNT_W (CNT_W)
  ) u_sat_upd (
    .i_cnt   (w_ctr_e),
    .i_taken (takenE),
    .o_cnt_c (w_ctr_nxt)
  );

  // No write bypass: decode sees the pre-update value in the update cycle.
  assign w_ctr_rd = r_mem[addrD];
  assign ctrD     = w_busy ? '0 : w_ctr_rd;
  assign predD    = !w_busy && w_ctr_rd[CNT_W-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upd_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (!w_busy) begin
      if (stat_clr) begin
        r_upd_cnt  <= '0;
        r_miss_cnt <= '0;
      end else if (w_upd_ok) begin
        if (r_upd_cnt != '1) r_upd_cnt <= r_upd_cnt + STAT_W'(1);
        if ((predE != takenE) && (r_miss_cnt != '1))
          r_miss_cnt <= r_miss_cnt + STAT_W'(1);
      end
    end
  end

  assign busy     = w_busy;
  assign upd_cnt  = r_upd_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_branch_pred_sat.sv
// Directed bench for branch_pred_sat: default table, a narrow-stat instance
// and a 3-bit-counter / 8-entry instance sharing clock and reset.
module tb_branch_pred_sat;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic [5:0]  addrD, addrE;
  logic        predD, updE, takenE, predE, busy, stat_clr;
  logic [1:0]  ctrD;
  logic [15:0] upd_cnt, miss_cnt;

  // STAT_W=4 instance
  logic [5:0]  addrD_s, addrE_s;
  logic        predD_s, updE_s, takenE_s, predE_s, busy_s, stat_clr_s;
  logic [1:0]  ctrD_s;
  logic [3:0]  upd_cnt_s, miss_cnt_s;

  // CNT_W=3, IDX_W=3 instance
  logic [2:0]  addrD_c, addrE_c;
  logic        predD_c, updE_c, takenE_c, predE_c, busy_c, stat_clr_c;
  logic [2:0]  ctrD_c;
  logic [15:0] upd_cnt_c, miss_cnt_c;

  branch_pred_sat dut (
    .clk(clk), .rst_n(rst_n), .addrD(addrD), .predD(predD), .ctrD(ctrD),
    .addrE(addrE), .updE(updE), .takenE(takenE), .predE(predE), .busy(busy),
    .stat_clr(stat_clr), .upd_cnt(upd_cnt), .miss_cnt(miss_cnt)
  );

  branch_pred_sat #(.STAT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .addrD(addrD_s), .predD(predD_s), .ctrD(ctrD_s),
    .addrE(addrE_s), .updE(updE_s), .takenE(takenE_s), .predE(predE_s), .busy(busy_s),
    .stat_clr(stat_clr_s), .upd_cnt(upd_cnt_s), .miss_cnt(miss_cnt_s)
  );

  branch_pred_sat #(.IDX_W(3), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .addrD(addrD_c), .predD(predD_c), .ctrD(ctrD_c),
    .addrE(addrE_c), .updE(updE_c), .takenE(takenE_c), .predE(predE_c), .busy(busy_c),
    .stat_clr(stat_clr_c), .upd_cnt(upd_cnt_c), .miss_cnt(miss_cnt_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int nc;
    logic [1:0] exp_up [4];
    logic [1:0] exp_dn [5];
    exp_up = '{2'd2, 2'd3, 2'd3, 2'd3};
    exp_dn = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

    rst_n = 1'b0;
    addrD = '0; addrE = '0; updE = 1'b0; takenE = 1'b0; predE = 1'b0; stat_clr = 1'b0;
    addrD_s = '0; addrE_s = '0; updE_s = 1'b0; takenE_s = 1'b0; predE_s = 1'b0; stat_clr_s = 1'b0;
    addrD_c = '0; addrE_c = '0; updE_c = 1'b0; takenE_c = 1'b0; predE_c = 1'b0; stat_clr_c = 1'b0;
    tick();
    tick();

    // 1. Reset state and init sweep length; updates during sweep ignored
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_predD", 32'(predD), 32'd0);
    check_eq("rst_ctrD", 32'(ctrD), 32'd0);
    check_eq("rst_upd_cnt", 32'(upd_cnt), 32'd0);
    rst_n = 1'b1;
    updE = 1'b1; takenE = 1'b1; predE = 1'b0; addrE = 6'd7;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    updE = 1'b0;
    check_eq("sweep_len", 32'(n), 32'd64);
    check_eq("sweep_upd_cnt", 32'(upd_cnt), 32'd0);
    check_eq("sweep_miss_cnt", 32'(miss_cnt), 32'd0);
    for (int i = 0; i < 64; i++) begin
      addrD = 6'(i);
      #1;
      check_eq($sformatf("init_ctr[%0d]", i), 32'(ctrD), 32'd1);
      check_eq($sformatf("init_pred[%0d]", i), 32'(predD), 32'd0);
    end

    // 2. Saturation up then down at entry 5
    addrD = 6'd5; addrE = 6'd5; updE = 1'b1; takenE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("up_ctr%0d", i), 32'(ctrD), 32'(exp_up[i]));
      check_eq($sformatf("up_pred%0d", i), 32'(predD), 32'd1);
    end
    takenE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("dn_ctr%0d", i), 32'(ctrD), 32'(exp_dn[i]));
    end
    updE = 1'b0;
    check_eq("dn_pred", 32'(predD), 32'd0);

    // 3. Same-cycle read/write: no bypass
    addrD = 6'd9; addrE = 6'd9; updE = 1'b1; takenE = 1'b1;
    #1;
    check_eq("nobyp_pred", 32'(predD), 32'd0);
    check_eq("nobyp_ctr", 32'(ctrD), 32'd1);
    tick();
    updE = 1'b0;
    check_eq("after_pred", 32'(predD), 32'd1);
    check_eq("after_ctr", 32'(ctrD), 32'd2);
    addrD = 6'd10;
    #1;
    check_eq("neigh_ctr", 32'(ctrD), 32'd1);

    // 4. Statistics, clear priority, narrow-counter saturation
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("clr_upd", 32'(upd_cnt), 32'd0);
    addrE = 6'd20; takenE = 1'b1; updE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      predE = (i >= 3);
      tick();
    end
    updE = 1'b0;
    check_eq("stat_upd", 32'(upd_cnt), 32'd10);
    check_eq("stat_miss", 32'(miss_cnt), 32'd3);
    stat_clr = 1'b1; updE = 1'b1; predE = 1'b0;
    tick();
    stat_clr = 1'b0; updE = 1'b0;
    check_eq("clrwin_upd", 32'(upd_cnt), 32'd0);
    check_eq("clrwin_miss", 32'(miss_cnt), 32'd0);
    addrE_s = 6'd3; updE_s = 1'b1; takenE_s = 1'b0; predE_s = 1'b1;
    repeat (20) tick();
    updE_s = 1'b0;
    check_eq("sat4_upd", 32'(upd_cnt_s), 32'd15);
    check_eq("sat4_miss", 32'(miss_cnt_s), 32'd15);

    // 5. Reset mid-sweep restarts it; table re-initialised
    addrE = 6'd40; addrD = 6'd40; updE = 1'b1; takenE = 1'b1;
    tick();
    tick();
    updE = 1'b0;
    check_eq("preload40", 32'(ctrD), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_eq("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    n = 0;
    nc = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (!busy_c && nc == 0) nc = n;
    end
    check_eq("resweep_len", 32'(n), 32'd64);
    check_eq("reinit40", 32'(ctrD), 32'd1);
    check_eq("reinit40_pred", 32'(predD), 32'd0);

    // 6. CNT_W=3, IDX_W=3 instance
    check_eq("c_sweep_len", 32'(nc), 32'd8);
    addrD_c = 3'd2; addrE_c = 3'd2;
    #1;
    check_eq("c_init_ctr", 32'(ctrD_c), 32'd3);
    check_eq("c_init_pred", 32'(predD_c), 32'd0);
    updE_c = 1'b1; takenE_c = 1'b1;
    tick();
    check_eq("c_one_ctr", 32'(ctrD_c), 32'd4);
    check_eq("c_one_pred", 32'(predD_c), 32'd1);
    repeat (7) tick();
    updE_c = 1'b0;
    check_eq("c_sat_ctr", 32'(ctrD_c), 32'd7);
    check_eq("c_sat_upd", 32'(upd_cnt_c), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pred_sat.md
Name: branch_pred_sat

Overview:
Parametrised branch history table: 2^IDX_W entries of CNT_W-bit saturating counters, replacing the 1-bit taken/not-taken store. Read combinationally at decode (addrD), trained at execute (addrE). A post-reset sweep initialises every entry. Update and mispredict counters support performance analysis.

Parameters:
IDX_W, 6, table index width; depth = 2^IDX_W entries
CNT_W, 2, counter width (>=1); prediction = counter MSB
INIT_VAL, 2**(CNT_W-1)-1, value written to every entry during init (weakly not-taken for CNT_W=2)
STAT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  synchronous active-low reset
addrD  in  IDX_W  decode-stage lookup index
predD  out  1  predicted taken for addrD
ctrD  out  CNT_W  raw counter at addrD (debug)
addrE  in  IDX_W  execute-stage update index
updE  in  1  update strobe (resolved branch in E)
takenE  in  1  actual outcome of branch in E
predE  in  1  prediction carried down the pipe for that branch
busy  out  1  init sweep in progress; predictions invalid
stat_clr  in  1  clear performance counters
upd_cnt  out  STAT_W  accepted updates
miss_cnt  out  STAT_W  accepted updates with predE != takenE

Behaviour:
- Clock is clk; reset is synchronous, active-low: sampled only on posedge clk when rst_n=0.
- FSM states: ST_INIT, ST_RUN.
- Reset (rst_n=0 at posedge): state<=ST_INIT, sweep ptr<=0, upd_cnt<=0, miss_cnt<=0. Table contents not touched by reset itself.
- ST_INIT: each cycle with rst_n=1, mem[ptr]<=INIT_VAL, ptr<=ptr+1. After the write to ptr=2^IDX_W-1, state<=ST_RUN. Sweep lasts exactly 2^IDX_W cycles after reset release.
- busy=1 in ST_INIT (including during reset), 0 in ST_RUN. While busy: predD=0, ctrD=0, updE ignored, stat counters frozen.
- Reset asserted mid-sweep restarts the sweep at ptr=0.
- ST_RUN read: ctrD=mem[addrD], predD=mem[addrD][CNT_W-1], combinational, zero latency.
- ST_RUN update at posedge with updE=1: takenE=1 -> counter+1, saturating at 2^CNT_W-1. takenE=0 -> counter-1, saturating at 0.
- No bypass: when addrD==addrE in the update cycle, predD shows the pre-update value. The new value is visible from the next cycle.
- Only one write port, so there are no write conflicts.
- upd_cnt+1 on each accepted update. miss_cnt+1 on each accepted update with predE!=takenE. Both saturate at all-ones; no wrap.
- stat_clr=1 zeroes both counters. If stat_clr coincides with an update, clear wins and the result is 0. stat_clr is ignored during reset; reset has priority.
- X on addrD/addrE is not checked; updE must not be X in ST_RUN.

Decomposition:
- Package branch_pred_pkg:
  - state enum {ST_INIT, ST_RUN}
  - CNT_W=2 named constants SNT=0, WNT=1, WT=2, ST=3
  - function sat_next(cnt, taken)
- One sub-module, bp_sat_upd: combinational next-counter logic, parametrised by CNT_W, instantiated once on the write path. Table and stat counters stay in the top module.

Test Plan:
1. Reset release, default params -> busy=1 for exactly 64 cycles, then 0. All 64 entries read ctrD=1, predD=0. Updates during the sweep leave upd_cnt=0.
2. Saturation at addrE=5: four updE with takenE=1 -> ctrD at addrD=5 steps 1,2,3,3 and predD turns 1 after the first update. Five with takenE=0 -> 3,2,1,0,0.
3. Same-cycle read/write at addr 9 (ctr=1), updE taken -> predD=0 that cycle, predD=1 and ctrD=2 the next cycle. Entry 10 unchanged.
4. Stats: 10 updates, 3 with predE!=takenE -> upd_cnt=10, miss_cnt=3. stat_clr asserted together with an update -> both 0. With STAT_W=4, 20 updates -> upd_cnt=15.
5. Reset mid-sweep: rst_n low at cycle 30 of the sweep, release -> busy stays 1 for a full 64 more cycles. Entry 40 (preloaded to 3 before reset) reads 1 afterwards.
6. CNT_W=3, IDX_W=3 -> sweep 8 cycles, INIT_VAL=3, predD=0. One taken update -> ctrD=4 and predD=1. Eight taken updates from the initial value -> saturates at 7.
